serial_fetch_unit: RTL and testbench

Bit-serial instruction fetch bridge between the chip's pins and the micro-coded CPU core. It accepts a fetch address from the core over a valid/ready request channel and shifts it off-chip on a single address pin, framed by a start bit. It then deserializes the start-framed instruction word returned on a single input pin. The assembled word, or a timeout error, goes back to the core over a valid/ready response channel.

---
 rtl/serial_fetch_unit.sv | 111 +++++++++++
 tb/tb_serial_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fetch_unit.sv
// Bit-serial fetch bridge: sends a start-framed address on one pin, collects a
// start-framed instruction word on another, and returns it (or a timeout) to the core.
module serial_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic               rsp_err,
  output logic               busy,
  output logic               addr_stream,
  input  logic               instr_in
);
  localparam int SW = $clog2(ADDR_W + 1) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int BW = $clog2(INSTR_W) + 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, HOLD} state_t;

  state_t             state, state_nx;
  logic               sync_q1, sync_in;
  logic [ADDR_W-1:0]  addr_q;
  logic [SW-1:0]      scnt;
  logic [WW-1:0]      wcnt;
  logic [BW-1:0]      bcnt;
  logic [INSTR_W-1:0] shreg;
  logic               send_last, wait_to, recv_last;

  assign send_last = (scnt == SW'(ADDR_W));
  assign wait_to   = (TIMEOUT != 0) && (wcnt == WW'(TIMEOUT - 1));
  assign recv_last = (bcnt == BW'(INSTR_W - 1));

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = SEND;
      SEND:    if (send_last) state_nx = WAIT;
      // a start bit on the final wait cycle beats the timeout
      WAIT:    if (sync_in) state_nx = RECV;
               else if (wait_to) state_nx = HOLD;
      RECV:    if (recv_last) state_nx = HOLD;
      HOLD:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1     <= 1'b0;
      sync_in     <= 1'b0;
      addr_q      <= '0;
      scnt        <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      addr_stream <= 1'b0;
      rsp_instr   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      sync_q1 <= instr_in;
      sync_in <= sync_q1;
      unique case (state)
        IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          scnt        <= '0;
          addr_stream <= 1'b1;
        end
        // addr_stream is registered, so each bit is loaded one cycle ahead
        SEND: begin
          scnt        <= scnt + SW'(1);
          addr_stream <= send_last ? 1'b0 : addr_q[ADDR_W-1];
          addr_q      <= {addr_q[ADDR_W-2:0], 1'b0};
          wcnt        <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + WW'(1);
          bcnt <= '0;
          if (!sync_in && wait_to) begin
            rsp_err   <= 1'b1;
            rsp_instr <= '0;
          end
        end
        RECV: begin
          bcnt  <= bcnt + BW'(1);
          shreg <= {shreg[INSTR_W-2:0], sync_in};
          if (recv_last) begin
            rsp_instr <= {shreg[INSTR_W-2:0], sync_in};
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fetch_unit.sv
// Scoreboard bench for serial_fetch_unit: stimulus pushes predicted responses,
// independent monitors check the address pin and the response channel.
module tb_serial_fetch_unit;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0, reset_n = 1'b0, req_valid = 1'b0;
  logic rr_man = 1'b1, rr_rand = 1'b1, bp_rand = 1'b0, pin_bit = 1'b0, glitch = 1'b0;
  logic [ADDR_W-1:0]  req_addr = '0;
  logic [INSTR_W-1:0] rsp_instr;
  logic req_ready, rsp_valid, rsp_err, busy, addr_stream, rsp_ready, instr_in;

  assign rsp_ready = bp_rand ? rr_rand : rr_man;
  assign instr_in  = pin_bit | glitch;

  serial_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err), .busy(busy),
    .addr_stream(addr_stream), .instr_in(instr_in)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int t; logic [INSTR_W-1:0] instr; logic err; } exp_t;
  typedef struct { int p; logic [INSTR_W-1:0] w; } pin_t;
  typedef struct { int e; logic [ADDR_W-1:0] a; } addr_t;

  exp_t  sbq[$];
  pin_t  pinq[$];
  addr_t addrq[$];
  int n_chk = 0, n_fail = 0, last_e = 0, rel = 0, p5 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: the wait phase begins right after the address frame; a reply
  // driven d cycles into it is seen on wait cycle d+2 (synchronizer), after
  // which one cycle enters receive and INSTR_W cycles collect the word.
  function automatic exp_t model(input int e, input int d, input logic [INSTR_W-1:0] w);
    exp_t x;
    int wait0 = e + ADDR_W + 1;
    if (d >= 0 && d + 2 < TIMEOUT) begin
      x.t = wait0 + (d + 2) + 1 + INSTR_W; x.instr = w; x.err = 1'b0;
    end else begin
      x.t = wait0 + TIMEOUT; x.instr = '0; x.err = 1'b1;
    end
    return x;
  endfunction

  // Call at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] w, input int d);
    int t = 0;
    req_valid = 1'b1; req_addr = a;
    while (!req_ready && t < 400) begin @(negedge clock); t++; end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_accept: got ready=0 expected ready=1 within 400 cycles");
      req_valid = 1'b0;
      return;
    end
    last_e = cyc + 1;
    sbq.push_back(model(last_e, d, w));
    if (d >= 0) pinq.push_back('{last_e + ADDR_W + 1 + d, w});
    addrq.push_back('{last_e, a});
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() > 0 || busy) && t < 3000) begin @(negedge clock); t++; end
    chk("drain", 32'(sbq.size() == 0 && !busy), 32'(1));
  endtask

  task automatic flush_model();
    sbq.delete(); pinq.delete(); addrq.delete();
  endtask

  // Pin model: start bit then the word MSB first, one bit per cycle.
  initial begin : pin_drv
    int off;
    forever begin
      @(negedge clock);
      pin_bit = 1'b0;
      if (reset_n && pinq.size() > 0 && cyc >= pinq[0].p) begin
        off = cyc - pinq[0].p;
        pin_bit = (off == 0) ? 1'b1 : pinq[0].w[INSTR_W - off];
        if (off >= INSTR_W) void'(pinq.pop_front());
      end
    end
  end

  initial begin : addr_mon
    int off;
    logic eb;
    forever begin
      @(negedge clock);
      if (reset_n && addrq.size() > 0 && cyc >= addrq[0].e) begin
        off = cyc - addrq[0].e;
        eb = (off == 0) ? 1'b1 : (off <= ADDR_W) ? addrq[0].a[ADDR_W - off] : 1'b0;
        chk("addr_stream", 32'(addr_stream), 32'(eb));
        if (off <= ADDR_W) chk("busy_send", 32'(busy), 32'(1));
        else void'(addrq.pop_front());
      end
    end
  end

  initial begin : rsp_mon
    logic prev;
    exp_t cur;
    prev = 1'b0;
    cur = '{0, '0, 1'b0};
    forever begin
      @(negedge clock);
      if (!reset_n) prev = 1'b0;
      else if (rsp_valid) begin
        if (!prev) begin
          if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
          end else begin
            cur = sbq.pop_front();
            chk("rsp_cycle", cyc, cur.t);
            chk("rsp_instr", 32'(rsp_instr), 32'(cur.instr));
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
          end
        end else begin
          chk("hold_instr", 32'(rsp_instr), 32'(cur.instr));
          chk("hold_err", 32'(rsp_err), 32'(cur.err));
        end
        chk("req_ready_hold", 32'(req_ready), 32'(0));
        prev = 1'b1;
      end else prev = 1'b0;
    end
  end

  initial forever begin
    @(posedge clock); #2;
    rr_rand = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d;
    // reset with random pin activity
    repeat (4) begin
      @(negedge clock);
      glitch = 1'($urandom); req_valid = 1'($urandom); req_addr = ADDR_W'($urandom);
    end
    chk("rst_addr_stream", 32'(addr_stream), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    glitch = 1'b0; req_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("rel_addr_stream", 32'(addr_stream), 32'(0));
    chk("rel_req_ready", 32'(req_ready), 32'(1));
    chk("rel_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rel_rsp_err", 32'(rsp_err), 32'(0));
    chk("rel_rsp_instr", 32'(rsp_instr), 32'(0));
    chk("rel_busy", 32'(busy), 32'(0));

    // basic fetch
    t = cyc;
    issue(8'hA5, 16'hBEEF, 3);
    chk("accept_idle", last_e, t + 1);
    drain();

    // backpressure with a second request waiting
    rr_man = 1'b0;
    issue(8'h3C, 16'hFFFF, 3);
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clock); t++; end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'(1));
    fork
      issue(8'h77, 16'h0F0F, 5);
      begin repeat (5) @(negedge clock); rel = cyc; rr_man = 1'b1; end
    join
    chk("accept_after_release", last_e, rel + 2);
    drain();

    // timeout, then start bit on the last wait cycle
    issue(8'h01, 16'h0000, -1);
    drain();
    issue(8'h01, 16'hC3A5, TIMEOUT - 3);
    drain();

    // reset during the start bit of the address frame
    issue(8'hA5, 16'h1111, 3);
    flush_model();
    chk("pre_rst_addr", 32'(addr_stream), 32'(1));
    reset_n = 1'b0; #1;
    chk("rst_send_addr", 32'(addr_stream), 32'(0));
    chk("rst_send_busy", 32'(busy), 32'(0));
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    // reset after 7 received data bits
    issue(8'h5A, 16'hA5A5, 3);
    p5 = last_e + ADDR_W + 1 + 3;
    t = 0;
    while (cyc < p5 + 10 && t < 200) begin @(negedge clock); t++; end
    chk("mid_recv_busy", 32'(busy), 32'(1));
    flush_model();
    reset_n = 1'b0; #1;
    chk("rst_recv_addr", 32'(addr_stream), 32'(0));
    chk("rst_recv_valid", 32'(rsp_valid), 32'(0));
    chk("rst_recv_ready", 32'(req_ready), 32'(1));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    issue(8'h3C, 16'h1234, 3);
    drain();

    // glitches in IDLE and SEND, then back-to-back fetches
    glitch = 1'b1; @(negedge clock); glitch = 1'b0;
    issue(8'h00, 16'h0000, 2);
    glitch = 1'b1; @(negedge clock); glitch = 1'b0;
    issue(8'hFF, 16'h8001, 4);
    drain();

    // randomized traffic with random response backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 3));
      issue(ADDR_W'($urandom), INSTR_W'($urandom), d);
    end
    drain();
    bp_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
